// File: rtl/uart_axil_master_pkg.sv
// Shared types and constants for the UART-command AXI4-Lite initiator.
package uart_axil_master_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_CSUM,
    S_WR,
    S_WR_B,
    S_RD,
    S_RD_R,
    S_TX_STATUS,
    S_TX_DATA
  } state_t;

  localparam logic [7:0] OP_WRITE   = 8'h01;
  localparam logic [7:0] OP_READ    = 8'h02;
  localparam logic [7:0] ST_BADOP   = 8'hFD;
  localparam logic [7:0] ST_BADCSUM = 8'hEE;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Status byte returned to the host for an AXI response code.
  function automatic logic [7:0] resp_status(input logic [1:0] resp);
    return {6'b0, resp};
  endfunction

endpackage

// File: rtl/uart_axil_master.sv
// UART byte-stream to AXI4-Lite single-beat initiator with status/data reply.
// Optional frame checksum byte enabled by defining UART_AXIL_MASTER_CSUM_EN.
module uart_axil_master
  import uart_axil_master_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH = 32
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [7:0]                rx_data_i,
  input  logic                      rx_valid_i,
  output logic                      rx_ready_o,
  output logic [7:0]                tx_data_o,
  output logic                      tx_valid_o,
  input  logic                      tx_ready_i,
  output logic [AXI_ADDR_WIDTH-1:0] m_aw_addr_o,
  output logic [2:0]                m_aw_prot_o,
  output logic                      m_aw_valid_o,
  input  logic                      m_aw_ready_i,
  output logic [31:0]               m_w_data_o,
  output logic [3:0]                m_w_strb_o,
  output logic                      m_w_valid_o,
  input  logic                      m_w_ready_i,
  input  logic [1:0]                m_b_resp_i,
  input  logic                      m_b_valid_i,
  output logic                      m_b_ready_o,
  output logic [AXI_ADDR_WIDTH-1:0] m_ar_addr_o,
  output logic [2:0]                m_ar_prot_o,
  output logic                      m_ar_valid_o,
  input  logic                      m_ar_ready_i,
  input  logic [31:0]               m_r_data_i,
  input  logic [1:0]                m_r_resp_i,
  input  logic                      m_r_valid_i,
  output logic                      m_r_ready_o,
  output logic                      busy_o,
  output state_t                    dbg_state_o
);

  localparam int AXI_DATA_WIDTH = 32;

  // Every channel transfers on a rising edge where valid & ready are both high;
  // a raised valid and its payload stay put until that edge, ready may toggle freely.

  state_t                    state_q;
  logic [1:0]                cnt_q;
  logic [31:0]               addr_q;
  logic [AXI_DATA_WIDTH-1:0] data_q;
  logic                      is_write_q;
  logic                      send_data_q;
`ifdef UART_AXIL_MASTER_CSUM_EN
  logic [7:0]                csum_q;
`endif

  logic rx_fire;
  logic frame_last;
  logic launch;
  logic aw_done;
  logic w_done;

  assign rx_fire = rx_valid_i & rx_ready_o;
  assign aw_done = !m_aw_valid_o || m_aw_ready_i;
  assign w_done  = !m_w_valid_o || m_w_ready_i;

  // Last address byte of a read or last data byte of a write.
  always_comb begin
    frame_last = 1'b0;
    case (state_q)
      S_ADDR:  frame_last = rx_fire && (cnt_q == 2'd3) && !is_write_q;
      S_DATA:  frame_last = rx_fire && (cnt_q == 2'd3);
      default: frame_last = 1'b0;
    endcase
  end

`ifdef UART_AXIL_MASTER_CSUM_EN
  assign launch = (state_q == S_CSUM) && rx_fire && (rx_data_i == csum_q);
`else
  assign launch = frame_last;
`endif

  assign m_aw_addr_o = addr_q[AXI_ADDR_WIDTH-1:0];
  assign m_ar_addr_o = addr_q[AXI_ADDR_WIDTH-1:0];
  assign m_aw_prot_o = 3'b000;
  assign m_ar_prot_o = 3'b000;
  assign m_w_data_o  = data_q;
  assign m_w_strb_o  = 4'hF;
  assign dbg_state_o = state_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      cnt_q        <= 2'd0;
      addr_q       <= '0;
      data_q       <= '0;
      is_write_q   <= 1'b0;
      send_data_q  <= 1'b0;
`ifdef UART_AXIL_MASTER_CSUM_EN
      csum_q       <= 8'h00;
`endif
      rx_ready_o   <= 1'b0;
      tx_data_o    <= 8'h00;
      tx_valid_o   <= 1'b0;
      m_aw_valid_o <= 1'b0;
      m_w_valid_o  <= 1'b0;
      m_b_ready_o  <= 1'b0;
      m_ar_valid_o <= 1'b0;
      m_r_ready_o  <= 1'b0;
      busy_o       <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (rx_fire) begin
            busy_o <= 1'b1;
`ifdef UART_AXIL_MASTER_CSUM_EN
            csum_q <= rx_data_i;
`endif
            if (rx_data_i == OP_WRITE || rx_data_i == OP_READ) begin
              is_write_q <= (rx_data_i == OP_WRITE);
              cnt_q      <= 2'd0;
              state_q    <= S_ADDR;
            end else begin
              rx_ready_o  <= 1'b0;
              tx_data_o   <= ST_BADOP;
              tx_valid_o  <= 1'b1;
              send_data_q <= 1'b0;
              state_q     <= S_TX_STATUS;
            end
          end else begin
            rx_ready_o <= 1'b1;
          end
        end
        S_ADDR: begin
          if (rx_fire) begin
            addr_q <= {addr_q[23:0], rx_data_i};
            cnt_q  <= cnt_q + 2'd1;
`ifdef UART_AXIL_MASTER_CSUM_EN
            csum_q <= csum_q ^ rx_data_i;
`endif
            if (cnt_q == 2'd3 && is_write_q) state_q <= S_DATA;
          end
        end
        S_DATA: begin
          if (rx_fire) begin
            data_q <= {data_q[23:0], rx_data_i};
            cnt_q  <= cnt_q + 2'd1;
`ifdef UART_AXIL_MASTER_CSUM_EN
            csum_q <= csum_q ^ rx_data_i;
`endif
          end
        end
`ifdef UART_AXIL_MASTER_CSUM_EN
        S_CSUM: begin
          if (rx_fire && rx_data_i != csum_q) begin
            rx_ready_o  <= 1'b0;
            tx_data_o   <= ST_BADCSUM;
            tx_valid_o  <= 1'b1;
            send_data_q <= 1'b0;
            state_q     <= S_TX_STATUS;
          end
        end
`endif
        S_WR: begin
          // AW and W retire independently; B is requested once both are gone.
          if (m_aw_ready_i) m_aw_valid_o <= 1'b0;
          if (m_w_ready_i)  m_w_valid_o  <= 1'b0;
          if (aw_done && w_done) begin
            m_b_ready_o <= 1'b1;
            state_q     <= S_WR_B;
          end
        end
        S_WR_B: begin
          if (m_b_valid_i) begin
            m_b_ready_o <= 1'b0;
            tx_data_o   <= resp_status(m_b_resp_i);
            tx_valid_o  <= 1'b1;
            send_data_q <= 1'b0;
            state_q     <= S_TX_STATUS;
          end
        end
        S_RD: begin
          if (m_ar_ready_i) begin
            m_ar_valid_o <= 1'b0;
            m_r_ready_o  <= 1'b1;
            state_q      <= S_RD_R;
          end
        end
        S_RD_R: begin
          if (m_r_valid_i) begin
            m_r_ready_o <= 1'b0;
            data_q      <= m_r_data_i;
            tx_data_o   <= resp_status(m_r_resp_i);
            tx_valid_o  <= 1'b1;
            send_data_q <= 1'b1;
            state_q     <= S_TX_STATUS;
          end
        end
        S_TX_STATUS: begin
          if (tx_ready_i) begin
            if (send_data_q) begin
              tx_data_o <= data_q[31:24];
              data_q    <= {data_q[23:0], 8'h00};
              cnt_q     <= 2'd0;
              state_q   <= S_TX_DATA;
            end else begin
              tx_valid_o <= 1'b0;
              rx_ready_o <= 1'b1;
              busy_o     <= 1'b0;
              state_q    <= S_IDLE;
            end
          end
        end
        S_TX_DATA: begin
          if (tx_ready_i) begin
            if (cnt_q == 2'd3) begin
              tx_valid_o <= 1'b0;
              rx_ready_o <= 1'b1;
              busy_o     <= 1'b0;
              state_q    <= S_IDLE;
            end else begin
              tx_data_o <= data_q[31:24];
              data_q    <= {data_q[23:0], 8'h00};
              cnt_q     <= cnt_q + 2'd1;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase

`ifdef UART_AXIL_MASTER_CSUM_EN
      if (frame_last) state_q <= S_CSUM;
`endif
      // Frame complete: raise the AXI request the very next cycle.
      if (launch) begin
        rx_ready_o <= 1'b0;
        if (is_write_q) begin
          m_aw_valid_o <= 1'b1;
          m_w_valid_o  <= 1'b1;
          state_q      <= S_WR;
        end else begin
          m_ar_valid_o <= 1'b1;
          state_q      <= S_RD;
        end
      end
    end
  end

endmodule
